// File: rtl/axi_rd_mem_responder.sv
// AXI4 read-only memory slave: one outstanding AR, programmable first-beat latency,
// INCR / WRAP bursts of 64-bit beats from a preloadable internal word array.
module axi_rd_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned RD_LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [3:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [63:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-4:0] wr_addr_i,
  input  logic [63:0]           wr_data_i
);
  localparam int unsigned AW    = ADDR_WIDTH - 3;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e              state_q;
  logic [63:0]         mem_q [DEPTH];
  logic [ID_WIDTH-1:0] id_q;
  logic [AW-1:0]       start_q;
  logic [3:0]          len_q;
  logic [3:0]          beat_q;
  logic                wrap_q;
  logic                err_q;
  logic [7:0]          cnt_q;

  logic                arready_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [63:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic [ID_WIDTH-1:0] rid_q;

  logic [3:0]          beat_d;
  logic [AW-1:0]       addr_d;
  logic [AW-1:0]       mask;
  logic                load;
  logic                req_err;
  logic                unused_addr_lo;

  assign unused_addr_lo = ^araddr_i[2:0];

  always_comb begin
    req_err = (arsize_i != 3'd3) || (arburst_i == 2'b00) || (arburst_i == 2'b11);
    if ((arburst_i == 2'b10) && !(arlen_i inside {4'd1, 4'd3, 4'd7, 4'd15}))
      req_err = 1'b1;
  end

  // Address of the beat being loaded next: beat 0 from WAIT, beat_q+1 during BURST.
  always_comb begin
    beat_d = (state_q == S_BURST) ? beat_q + 4'd1 : '0;
    mask   = AW'(len_q);
    addr_d = start_q + AW'(beat_d);
    if (wrap_q)
      addr_d = (start_q & ~mask) | (addr_d & mask);
  end

  assign load = ((state_q == S_WAIT) && (cnt_q == 8'd0)) ||
                ((state_q == S_BURST) && rready_i && !rlast_q);

  always_ff @(posedge clk) begin
    if (wr_en_i)
      mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      start_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arvalid_i && arready_q) begin
            id_q      <= arid_i;
            start_q   <= araddr_i[ADDR_WIDTH-1:3];
            len_q     <= arlen_i;
            wrap_q    <= (arburst_i == 2'b10);
            err_q     <= req_err;
            cnt_q     <= 8'(RD_LATENCY - 1);
            arready_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            rid_q    <= id_q;
            rvalid_q <= 1'b1;
            state_q  <= S_BURST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_BURST: begin
          if (rready_i && rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Array read uses pre-edge contents, so a same-edge preload write is not visible.
      if (load) begin
        beat_q  <= beat_d;
        rdata_q <= err_q ? '0 : mem_q[addr_d];
        rresp_q <= err_q ? 2'b10 : 2'b00;
        rlast_q <= (beat_d == len_q);
      end
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rid_o     = rid_q;

endmodule

// File: doc/axi_rd_mem_responder.md
Name: axi_rd_mem_responder

Overview:
AXI4 read-only slave that answers the cache controller's memory-side read requests (mem_ar*/mem_r* channels). It accepts one AR request at a time and waits a programmable first-beat latency. It then returns a 64-bit R burst from an internal word array, using INCR or critical-word-first WRAP addressing. A side write port preloads the array. The block is synthesizable and replaces the behavioural memory model for timing-accurate miss-penalty studies.

Parameters:
ADDR_WIDTH, 16, byte-address width; array holds 2^(ADDR_WIDTH-3) 64-bit words.
ID_WIDTH, 4, width of arid/rid.
RD_LATENCY, 8, cycles from AR handshake to first rvalid; legal range 1..255.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-high.
arid_i  in  ID_WIDTH  request ID.
araddr_i  in  ADDR_WIDTH  start byte address.
arlen_i  in  4  beats minus one.
arsize_i  in  3  beat size; only 3 (8 B) is supported.
arburst_i  in  2  01 INCR, 10 WRAP.
arvalid_i  in  1  AR valid.
arready_o  out  1  AR ready.
rid_o  out  ID_WIDTH  echoed arid.
rdata_o  out  64  read data.
rresp_o  out  2  00 OKAY, 10 SLVERR.
rlast_o  out  1  final beat.
rvalid_o  out  1  R valid.
rready_i  in  1  R ready.
wr_en_i  in  1  preload write strobe.
wr_addr_i  in  ADDR_WIDTH-3  preload word index.
wr_data_i  in  64  preload data.

Behaviour:
- Reset (rst_n=1, async): arready_o=1, rvalid_o=0, rlast_o=0, rdata_o=0, rresp_o=00, rid_o=0. FSM goes to IDLE, latency counter and beat counter clear. Array contents are not reset. An in-flight burst is abandoned and no further beats issue.
- FSM states:
  - IDLE: arready_o=1. On arvalid_i&arready_o, latch id, word address (araddr_i[ADDR_WIDTH-1:3]), len, burst, and error flag. Go to WAIT and drop arready_o on the next edge.
  - WAIT: the counter loads RD_LATENCY-1 and decrements. When it reaches 0, load beat 0 and go to BURST, so rvalid_o rises exactly RD_LATENCY cycles after the AR handshake edge.
  - BURST: rvalid_o=1. rdata_o, rid_o, rresp_o and rlast_o stay stable while rready_i=0. On rvalid&rready, if the beat is not last, load the next beat on the same edge (back-to-back, no bubble). If it is last, go to IDLE with rvalid_o=0 and arready_o=1 on the following cycle. There is no same-cycle AR acceptance on the last beat.
- Error flag: set when arsize_i≠3, arburst_i is 00 or 11, or arburst=WRAP with arlen∉{1,3,7,15}. On error, all arlen+1 beats return rresp=10 and rdata=0, and the length is still honoured.
- Address arithmetic per beat k (word units):
  - INCR: start+k, modulo the array size (wraps at the top of the array).
  - WRAP: base = start & ~len; addr = base | ((start+k) & len). Example: start word 5, len 7 gives 5,6,7,0,1,2,3,4 within the aligned 8-word line.
  - Unaligned araddr low bits [2:0] are ignored.
- rlast_o=1 only on beat k=arlen; arlen=0 gives a single beat with rlast=1.
- Preload port: synchronous write on clk when wr_en_i=1, accepted in any state. A beat loaded on the same edge as a write to the same word returns the old data. Later beats see the new data.
- arready_o=0 in WAIT and BURST; arvalid_i is ignored there, and the master must hold its request.

Test Plan:
- Preload word i with {32'hA5A5_0000+i, i}. Send INCR araddr=0x0040, len=7, id=3 with rready tied high → first rvalid 8 cycles after the handshake. Expect 8 consecutive beats of words 8..15, rid=3, rresp=00, rlast only on the 8th beat.
- WRAP araddr=0x0128 (word 37), len=7 → beat order words 37,38,39,32,33,34,35,36.
- Random rready stalls (≈50% duty) on the above WRAP burst → each beat's data, rid and rlast stay stable until accepted. Exactly 8 handshakes occur and arready stays 0 until one cycle after the last handshake.
- Three errored requests: arsize=2 len=3, arburst=00 len=0, and WRAP len=5 → 4, 1 and 6 beats respectively, each with rresp=10 and rdata=0. The next legal request then returns OKAY.
- Assert rst_n=1 during beat 3 of an 8-beat burst → rvalid drops asynchronously and arready=1 after release. A fresh request returns the preloaded data unchanged.
- wr_en writing word 9 to 64'hDEAD on the same edge that beat 1 (word 9) loads → beat 1 returns the old value. A repeat read returns 64'hDEAD.
